// File: rtl/alarm_key_fsm.sv
// ============================================================================
// alarm_key_fsm : keypad entry buffer and load/display sequencing for alarm clock
// Revision 1.0  : initial release
// ============================================================================
`default_nettype none

module alarm_key_fsm #(
  parameter logic [3:0] NOKEY       = 4'd10,
  parameter int         TIMEOUT_SEC = 10,
  parameter int         TIMEOUT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic       alarm_button,
  input  logic       time_button,
  input  logic [3:0] key,
  output logic       load_new_c,
  output logic       load_new_a,
  output logic       show_a,
  output logic       show_new_time,
  output logic [3:0] buf_ms_hr,
  output logic [3:0] buf_ls_hr,
  output logic [3:0] buf_ms_min,
  output logic [3:0] buf_ls_min
);

  localparam logic [TIMEOUT_W-1:0] c_timeout = TIMEOUT_W'(TIMEOUT_SEC);

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    KEY_WAITED       = 3'd2,
    KEY_ENTRY        = 3'd3,
    SET_ALARM_TIME   = 3'd4,
    SET_CURRENT_TIME = 3'd5,
    SHOW_ALARM       = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [TIMEOUT_W-1:0] r_count;
  logic [3:0]           r_key;
  logic                 w_valid_key;
  logic                 w_timeout;

  // Codes NOKEY and above all mean "no key pressed".
  assign w_valid_key = (key < NOKEY);
  assign w_timeout   = (r_count == c_timeout);

  always_comb begin
    w_next = r_state;
    case (r_state)
      SHOW_TIME: begin
        if (alarm_button)     w_next = SHOW_ALARM;
        else if (w_valid_key) w_next = KEY_STORED;
      end
      KEY_STORED: w_next = KEY_WAITED;
      KEY_WAITED: begin
        if (!w_valid_key)   w_next = KEY_ENTRY;
        else if (w_timeout) w_next = SHOW_TIME;
      end
      KEY_ENTRY: begin
        if (alarm_button)     w_next = SET_ALARM_TIME;
        else if (time_button) w_next = SET_CURRENT_TIME;
        else if (w_timeout)   w_next = SHOW_TIME;
        else if (w_valid_key) w_next = KEY_STORED;
      end
      SET_ALARM_TIME:   w_next = SHOW_TIME;
      SET_CURRENT_TIME: w_next = SHOW_TIME;
      SHOW_ALARM: begin
        if (!alarm_button) w_next = SHOW_TIME;
      end
      default: w_next = SHOW_TIME;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= SHOW_TIME;
    else        r_state <= w_next;
  end

  // Idle timer runs only while waiting on the user; passing through KEY_STORED restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (r_state == KEY_WAITED || r_state == KEY_ENTRY) begin
      if (one_second && !w_timeout) r_count <= r_count + 1'b1;
    end else begin
      r_count <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key      <= '0;
      buf_ms_hr  <= '0;
      buf_ls_hr  <= '0;
      buf_ms_min <= '0;
      buf_ls_min <= '0;
    end else begin
      if (w_next == KEY_STORED) r_key <= key;
      if (r_state == SHOW_TIME) begin
        buf_ms_hr  <= '0;
        buf_ls_hr  <= '0;
        buf_ms_min <= '0;
        buf_ls_min <= '0;
      end else if (r_state == KEY_STORED) begin
        buf_ms_hr  <= buf_ls_hr;
        buf_ls_hr  <= buf_ms_min;
        buf_ms_min <= buf_ls_min;
        buf_ls_min <= r_key;
      end
    end
  end

  assign load_new_c    = (r_state == SET_CURRENT_TIME);
  assign load_new_a    = (r_state == SET_ALARM_TIME);
  assign show_a        = (r_state == SHOW_ALARM);
  assign show_new_time = (r_state == KEY_STORED) || (r_state == KEY_WAITED) ||
                         (r_state == KEY_ENTRY);

endmodule

`default_nettype wire

// File: tb/tb_alarm_key_fsm.sv
// ============================================================================
// tb_alarm_key_fsm : directed bench with an entry-session model for alarm_key_fsm
// Revision 1.0     : initial release
// ============================================================================
`default_nettype none

module tb_alarm_key_fsm;

  localparam logic [3:0] NOKEY = 4'd10;
  localparam int         TO    = 10;

  localparam int M_IDLE   = 0;
  localparam int M_ENTRY  = 1;
  localparam int M_ALARM  = 2;
  localparam int M_LOAD_A = 3;
  localparam int M_LOAD_C = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       one_second;
  logic       alarm_button;
  logic       time_button;
  logic [3:0] key;
  logic       load_new_c;
  logic       load_new_a;
  logic       show_a;
  logic       show_new_time;
  logic [3:0] buf_ms_hr;
  logic [3:0] buf_ls_hr;
  logic [3:0] buf_ms_min;
  logic [3:0] buf_ls_min;

  int errors = 0;
  int checks = 0;

  alarm_key_fsm #(.NOKEY(NOKEY), .TIMEOUT_SEC(TO), .TIMEOUT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .one_second   (one_second),
    .alarm_button (alarm_button),
    .time_button  (time_button),
    .key          (key),
    .load_new_c   (load_new_c),
    .load_new_a   (load_new_a),
    .show_a       (show_a),
    .show_new_time(show_new_time),
    .buf_ms_hr    (buf_ms_hr),
    .buf_ls_hr    (buf_ls_hr),
    .buf_ms_min   (buf_ms_min),
    .buf_ls_min   (buf_ls_min)
  );

  always #5 clk = ~clk;

  wire [15:0] dut_buf = {buf_ms_hr, buf_ls_hr, buf_ms_min, buf_ls_min};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Session model: an entry session captures a digit, appends it to the entered
  // number, waits for release, then accepts more digits, a command or idles out.
  int          m_mode;
  logic        m_fresh;
  logic        m_wait;
  logic [15:0] m_digits;
  logic [3:0]  m_key;
  int          m_idle;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode <= M_IDLE; m_fresh <= 1'b0; m_wait <= 1'b0;
      m_digits <= '0; m_key <= '0; m_idle <= 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          m_digits <= '0; m_idle <= 0; m_wait <= 1'b0;
          if (alarm_button) m_mode <= M_ALARM;
          else if (key < 10) begin m_mode <= M_ENTRY; m_fresh <= 1'b1; m_key <= key; end
        end
        M_ENTRY: begin
          if (m_fresh) begin
            m_digits <= {m_digits[11:0], m_key};
            m_fresh <= 1'b0; m_wait <= 1'b1; m_idle <= 0;
          end else begin
            if (one_second && m_idle < TO) m_idle <= m_idle + 1;
            if (m_wait) begin
              if (key > 9) m_wait <= 1'b0;
              else if (m_idle == TO) m_mode <= M_IDLE;
            end else if (alarm_button) m_mode <= M_LOAD_A;
            else if (time_button) m_mode <= M_LOAD_C;
            else if (m_idle == TO) m_mode <= M_IDLE;
            else if (key < 10) begin m_fresh <= 1'b1; m_key <= key; end
          end
        end
        M_ALARM: begin
          m_idle <= 0;
          if (!alarm_button) m_mode <= M_IDLE;
        end
        default: begin m_mode <= M_IDLE; m_idle <= 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("load_new_c", {15'd0, load_new_c}, {15'd0, m_mode == M_LOAD_C});
    chk("load_new_a", {15'd0, load_new_a}, {15'd0, m_mode == M_LOAD_A});
    chk("show_a", {15'd0, show_a}, {15'd0, m_mode == M_ALARM});
    chk("show_new_time", {15'd0, show_new_time}, {15'd0, m_mode == M_ENTRY});
    chk("buf", dut_buf, m_digits);
  end

  // Advance n falling edges, then settle 1ns before driving or spot-checking.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int rel);
    key = k;     step(hold);
    key = NOKEY; step(rel);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; one_second = 1'b0; alarm_button = 1'b0; time_button = 1'b0; key = NOKEY;
    step(3);
    reset = 1'b1; step(2);
    chk("t1 buf", dut_buf, 16'h0000);
    chk("t1 show_new_time", {15'd0, show_new_time}, 16'd0);

    press(4'd1, 3, 2); press(4'd2, 3, 2); press(4'd3, 3, 2); press(4'd4, 3, 2);
    chk("t2 buf before cmd", dut_buf, 16'h1234);
    time_button = 1'b1; step(1);
    chk("t2 load_new_c", {15'd0, load_new_c}, 16'd1);
    chk("t2 buf at load", dut_buf, 16'h1234);
    time_button = 1'b0; step(1);
    chk("t2 load_new_c drop", {15'd0, load_new_c}, 16'd0);
    step(1);
    chk("t2 buf cleared", dut_buf, 16'h0000);

    key = 4'd7; step(1);
    for (int i = 0; i < 19; i++) begin
      step(1);
      chk("t3 held buf", dut_buf, 16'h0007);
    end
    key = NOKEY; step(2);
    chk("t3 one shift", dut_buf, 16'h0007);

    press(4'd5, 1, 2);
    chk("t4 buf", dut_buf, 16'h0075);
    for (int i = 1; i <= TO; i++) begin
      if (i == TO) chk("t4 still entry", {15'd0, show_new_time}, 16'd1);
      one_second = 1'b1; step(1);
      one_second = 1'b0; step(2);
    end
    chk("t4 timed out", {15'd0, show_new_time}, 16'd0);
    chk("t4 buf cleared", dut_buf, 16'h0000);

    press(4'd3, 1, 2);
    alarm_button = 1'b1; time_button = 1'b1; step(1);
    chk("t5 load_new_a", {15'd0, load_new_a}, 16'd1);
    chk("t5 no load_new_c", {15'd0, load_new_c}, 16'd0);
    time_button = 1'b0; step(2);
    chk("t5 show_a", {15'd0, show_a}, 16'd1);
    step(3);
    chk("t5 show_a held", {15'd0, show_a}, 16'd1);
    alarm_button = 1'b0; step(1);
    chk("t5 show_a released", {15'd0, show_a}, 16'd0);

    step(1);
    press(4'd9, 1, 2);
    key = 4'd3; step(2);
    chk("t6 buf", dut_buf, 16'h0093);
    reset = 1'b0; #1;
    chk("t6 async buf", dut_buf, 16'h0000);
    chk("t6 async show_new_time", {15'd0, show_new_time}, 16'd0);
    key = NOKEY; step(2);
    reset = 1'b1; step(2);
    chk("t6 after reset", dut_buf, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
